// File: rtl/axi_master_pkg.sv
// ---------------------------------------------------------------------------
// axi_master_pkg
// Shared definitions for the TL_RX AXI master request path: bus widths,
// burst encodings, packer FSM state encoding and the Ax channel layout.
// The Ax channel width is computed here so that the request packer and the
// downstream request controller always agree on the FIFO entry format.
// ---------------------------------------------------------------------------
package axi_master_pkg;

  localparam int DW                = 32;
  localparam int BEAT_SIZE         = 32 * DW;
  localparam int ADDR_WIDTH        = 64;
  localparam int ID_WIDTH          = 10;
  localparam int AxLEN_FIELD_WIDTH = 8;
  localparam int QOS_WIDTH         = 4;
  localparam int USER_SIG_WIDTH    = 12;
  localparam int BURST_WIDTH       = 2;
  localparam int STROBE_BUS_WIDTH  = BEAT_SIZE / 8;
  localparam int W_CHANNEL_WIDTH   = BEAT_SIZE + STROBE_BUS_WIDTH;

  // A beat holds 32 DW lanes; the lane index is the low part of the global
  // DW index, the beat index is the high part.
  localparam int LANES_PER_BEAT = BEAT_SIZE / DW;
  localparam int LANE_IDX_WIDTH = 5;
  localparam int LEN_DW_WIDTH   = 10;
  // Holds 1..1024 and the end index s+len-1 (at most 1054).
  localparam int DW_COUNT_WIDTH = 11;
  // Beat index 0..32 (a 1024-DW request starting at lane 31 spans 33 beats).
  localparam int BEAT_IDX_WIDTH = DW_COUNT_WIDTH - LANE_IDX_WIDTH;

  function automatic int calc_ax_channel_width(input int id_w, input int addr_w,
                                               input int len_w, input int qos_w,
                                               input int user_w);
    return id_w + addr_w + len_w + BURST_WIDTH + qos_w + user_w;
  endfunction

  localparam int Ax_CHANNEL_WIDTH = calc_ax_channel_width(ID_WIDTH, ADDR_WIDTH,
                                                          AxLEN_FIELD_WIDTH,
                                                          QOS_WIDTH,
                                                          USER_SIG_WIDTH);

  typedef enum logic [BURST_WIDTH-1:0] {
    BURST_FIXED     = 2'b00,
    BURST_INCREMENT = 2'b01,
    BURST_WRAP      = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HDR_PUSH = 2'd1,
    W_STREAM = 2'd2
  } packer_state_e;

  // Field order from MSB down: {ID, ADDR, LEN, BURST, QOS, USER}
  typedef struct packed {
    logic [ID_WIDTH-1:0]          id;
    logic [ADDR_WIDTH-1:0]        addr;
    logic [AxLEN_FIELD_WIDTH-1:0] len;
    axi_burst_e                   burst;
    logic [QOS_WIDTH-1:0]         qos;
    logic [USER_SIG_WIDTH-1:0]    user;
  } ax_channel_t;

endpackage

// File: rtl/axi_master_strobe_gen.sv
// ---------------------------------------------------------------------------
// axi_master_strobe_gen
// Combinational WSTRB generator for one W beat. Every DW lane j of beat b
// has global DW index g = b*32 + j, which is classified against the first
// (s) and last (e) DW of the request:
//   g == s      -> first_be (also covers single-DW requests, where s == e)
//   g == e      -> last_be
//   s < g < e   -> all four bytes
//   otherwise   -> no bytes
// Ports:
//   s         first DW lane of the request within beat 0
//   e         global index of the last DW (s + len - 1)
//   beat_idx  index of the beat being produced
//   first_be  byte enables of the first DW
//   last_be   byte enables of the last DW
//   strobe    STROBE_BUS_WIDTH byte strobes, 4 bits per DW lane
// ---------------------------------------------------------------------------
module axi_master_strobe_gen
  import axi_master_pkg::*;
(
  input  logic [LANE_IDX_WIDTH-1:0]   s,
  input  logic [DW_COUNT_WIDTH-1:0]   e,
  input  logic [BEAT_IDX_WIDTH-1:0]   beat_idx,
  input  logic [3:0]                  first_be,
  input  logic [3:0]                  last_be,
  output logic [STROBE_BUS_WIDTH-1:0] strobe
);

  logic [DW_COUNT_WIDTH-1:0] s_ext;

  assign s_ext = DW_COUNT_WIDTH'(s);

  // The first_be test comes first so a single-DW request (s == e) takes
  // first_be and ignores last_be.
  for (genvar j = 0; j < LANES_PER_BEAT; j++) begin : g_lane
    logic [DW_COUNT_WIDTH-1:0] g;

    assign g = {beat_idx, LANE_IDX_WIDTH'(j)};

    assign strobe[4*j +: 4] = (g == s_ext)               ? first_be :
                              (g == e)                   ? last_be  :
                              ((g > s_ext) && (g < e))   ? 4'hF     :
                                                           4'h0;
  end

endmodule

// File: rtl/axi_master_request_packer.sv
// ---------------------------------------------------------------------------
// axi_master_request_packer
// Converts decoded memory-request TLP headers plus address-aligned payload
// beats into AW/W/AR FIFO entries for the AXI master request controller.
// One request is in flight at a time, so header order is preserved and the
// read and write paths never push simultaneously.
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_tlp_*, o_tlp_ready     header handshake and fields
//   i_data*, o_data_ready    payload beat handshake (data already lane-aligned)
//   o_AW_CHANNEL_fifo, o_aw_fifo_wr_en, i_aw_fifo_full   AW FIFO push side
//   o_W_CHANNEL_fifo,  o_w_fifo_wr_en,  i_w_fifo_full    W FIFO push side
//   o_AR_CHANNEL_fifo, o_ar_fifo_wr_en, i_ar_fifo_full   AR FIFO push side
//   o_len_err                one-cycle pulse when i_data_last disagrees with
//                            the beat count derived from the header
// ---------------------------------------------------------------------------
module axi_master_request_packer
  import axi_master_pkg::*;
(
  input  logic                          i_clk,
  input  logic                          i_rst,

  input  logic                          i_tlp_valid,
  output logic                          o_tlp_ready,
  input  logic                          i_tlp_is_write,
  input  logic [ADDR_WIDTH-1:0]         i_tlp_addr,
  input  logic [LEN_DW_WIDTH-1:0]       i_tlp_len_dw,
  input  logic [3:0]                    i_tlp_first_be,
  input  logic [3:0]                    i_tlp_last_be,
  input  logic [ID_WIDTH-1:0]           i_tlp_tag,
  input  logic [2:0]                    i_tlp_tc,
  input  logic [USER_SIG_WIDTH-1:0]     i_tlp_user,

  input  logic                          i_data_valid,
  input  logic [BEAT_SIZE-1:0]          i_data,
  input  logic                          i_data_last,
  output logic                          o_data_ready,

  output logic [Ax_CHANNEL_WIDTH-1:0]   o_AW_CHANNEL_fifo,
  output logic                          o_aw_fifo_wr_en,
  input  logic                          i_aw_fifo_full,

  output logic [W_CHANNEL_WIDTH-1:0]    o_W_CHANNEL_fifo,
  output logic                          o_w_fifo_wr_en,
  input  logic                          i_w_fifo_full,

  output logic [Ax_CHANNEL_WIDTH-1:0]   o_AR_CHANNEL_fifo,
  output logic                          o_ar_fifo_wr_en,
  input  logic                          i_ar_fifo_full,

  output logic                          o_len_err
);

  packer_state_e               state;
  logic                        is_write_q;
  ax_channel_t                 ax_q;
  logic [3:0]                  first_be_q;
  logic [3:0]                  last_be_q;
  logic [LANE_IDX_WIDTH-1:0]   start_q;
  logic [DW_COUNT_WIDTH-1:0]   end_q;
  logic [BEAT_IDX_WIDTH-1:0]   beat_cnt;
  logic                        len_err_q;

  logic [DW_COUNT_WIDTH-1:0]   hdr_len;
  logic [LANE_IDX_WIDTH-1:0]   hdr_start;
  logic [DW_COUNT_WIDTH-1:0]   hdr_end;
  ax_channel_t                 hdr_ax;

  logic                        tlp_fire;
  logic                        aw_push;
  logic                        ar_push;
  logic                        data_ready;
  logic                        w_push;
  logic                        last_beat;
  logic [STROBE_BUS_WIDTH-1:0] w_strobe;

  // Header-derived values. A length field of 0 means 1024 DW. The start lane
  // is the DW offset inside a 128-byte beat; the end index can run past the
  // first beat, and its upper bits are exactly the number of extra beats.
  always_comb begin
    hdr_len    = (i_tlp_len_dw == '0) ? DW_COUNT_WIDTH'(1024)
                                      : DW_COUNT_WIDTH'(i_tlp_len_dw);
    hdr_start  = i_tlp_addr[6:2];
    hdr_end    = DW_COUNT_WIDTH'(hdr_start) + hdr_len - DW_COUNT_WIDTH'(1);

    hdr_ax       = '0;
    hdr_ax.id    = i_tlp_tag;
    hdr_ax.addr  = i_tlp_addr;
    hdr_ax.len   = AxLEN_FIELD_WIDTH'(hdr_end[DW_COUNT_WIDTH-1:LANE_IDX_WIDTH]);
    hdr_ax.burst = BURST_INCREMENT;
    hdr_ax.qos   = QOS_WIDTH'(i_tlp_tc);
    hdr_ax.user  = i_tlp_user;
  end

  // Handshake qualifiers. FIFO pushes follow the full flags combinationally
  // so a push can happen in the first cycle the FIFO has room.
  always_comb begin
    tlp_fire   = i_tlp_valid && (state == IDLE);
    aw_push    = (state == HDR_PUSH) && is_write_q && !i_aw_fifo_full;
    ar_push    = (state == HDR_PUSH) && !is_write_q && !i_ar_fifo_full;
    data_ready = (state == W_STREAM) && !i_w_fifo_full;
    w_push     = i_data_valid && data_ready;
    last_beat  = (AxLEN_FIELD_WIDTH'(beat_cnt) == ax_q.len);
  end

  // Request state machine. The beat count derived from the header is the
  // only thing that ends a W burst; i_data_last is checked against it but
  // never changes the sequencing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      len_err_q <= 1'b0;
    end else begin
      len_err_q <= w_push && (i_data_last != last_beat);
      case (state)
        IDLE: begin
          if (tlp_fire) begin
            state <= HDR_PUSH;
          end
        end
        HDR_PUSH: begin
          if (aw_push) begin
            state    <= W_STREAM;
            beat_cnt <= '0;
          end else if (ar_push) begin
            state <= IDLE;
          end
        end
        W_STREAM: begin
          if (w_push) begin
            beat_cnt <= beat_cnt + BEAT_IDX_WIDTH'(1);
            if (last_beat) begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Header capture. These registers are only consumed after a handshake has
  // reloaded them, so they need no reset.
  always_ff @(posedge i_clk) begin
    if (tlp_fire) begin
      is_write_q <= i_tlp_is_write;
      ax_q       <= hdr_ax;
      first_be_q <= i_tlp_first_be;
      last_be_q  <= i_tlp_last_be;
      start_q    <= hdr_start;
      end_q      <= hdr_end;
    end
  end

  axi_master_strobe_gen u_strobe_gen (
    .s        (start_q),
    .e        (end_q),
    .beat_idx (beat_cnt),
    .first_be (first_be_q),
    .last_be  (last_be_q),
    .strobe   (w_strobe)
  );

  assign o_tlp_ready       = (state == IDLE);
  assign o_data_ready      = data_ready;
  assign o_aw_fifo_wr_en   = aw_push;
  assign o_ar_fifo_wr_en   = ar_push;
  assign o_w_fifo_wr_en    = w_push;
  assign o_AW_CHANNEL_fifo = ax_q;
  assign o_AR_CHANNEL_fifo = ax_q;
  assign o_W_CHANNEL_fifo  = {i_data, w_strobe};
  assign o_len_err         = len_err_q;

endmodule

// File: tb/tb_axi_master_request_packer.sv
// ---------------------------------------------------------------------------
// tb_axi_master_request_packer
// Directed and randomized requests against axi_master_request_packer. A
// negedge monitor collects every FIFO push; expected entries are computed
// from the request fields with plain arithmetic over the DW range of each
// request.
// ---------------------------------------------------------------------------
module tb_axi_master_request_packer;
  import axi_master_pkg::*;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [9:0]  len_dw;
    logic [3:0]  fbe;
    logic [3:0]  lbe;
    logic [9:0]  tag;
    logic [2:0]  tc;
    logic [11:0] user;
  } req_t;

  logic                        i_clk;
  logic                        i_rst;
  logic                        i_tlp_valid;
  logic                        o_tlp_ready;
  logic                        i_tlp_is_write;
  logic [ADDR_WIDTH-1:0]       i_tlp_addr;
  logic [9:0]                  i_tlp_len_dw;
  logic [3:0]                  i_tlp_first_be;
  logic [3:0]                  i_tlp_last_be;
  logic [ID_WIDTH-1:0]         i_tlp_tag;
  logic [2:0]                  i_tlp_tc;
  logic [USER_SIG_WIDTH-1:0]   i_tlp_user;
  logic                        i_data_valid;
  logic [BEAT_SIZE-1:0]        i_data;
  logic                        i_data_last;
  logic                        o_data_ready;
  logic [Ax_CHANNEL_WIDTH-1:0] o_AW_CHANNEL_fifo;
  logic                        o_aw_fifo_wr_en;
  logic                        i_aw_fifo_full;
  logic [W_CHANNEL_WIDTH-1:0]  o_W_CHANNEL_fifo;
  logic                        o_w_fifo_wr_en;
  logic                        i_w_fifo_full;
  logic [Ax_CHANNEL_WIDTH-1:0] o_AR_CHANNEL_fifo;
  logic                        o_ar_fifo_wr_en;
  logic                        i_ar_fifo_full;
  logic                        o_len_err;

  int checks = 0;
  int errors = 0;

  bit toggle_w   = 1'b0;
  bit stall_rand = 1'b0;

  logic [99:0]   aw_q[$];
  logic [99:0]   ar_q[$];
  logic [1023:0] wd_q[$];
  logic [127:0]  ws_q[$];
  logic [1023:0] sent_q[$];
  int            err_pulses;

  axi_master_request_packer dut (
    .i_clk             (i_clk),
    .i_rst             (i_rst),
    .i_tlp_valid       (i_tlp_valid),
    .o_tlp_ready       (o_tlp_ready),
    .i_tlp_is_write    (i_tlp_is_write),
    .i_tlp_addr        (i_tlp_addr),
    .i_tlp_len_dw      (i_tlp_len_dw),
    .i_tlp_first_be    (i_tlp_first_be),
    .i_tlp_last_be     (i_tlp_last_be),
    .i_tlp_tag         (i_tlp_tag),
    .i_tlp_tc          (i_tlp_tc),
    .i_tlp_user        (i_tlp_user),
    .i_data_valid      (i_data_valid),
    .i_data            (i_data),
    .i_data_last       (i_data_last),
    .o_data_ready      (o_data_ready),
    .o_AW_CHANNEL_fifo (o_AW_CHANNEL_fifo),
    .o_aw_fifo_wr_en   (o_aw_fifo_wr_en),
    .i_aw_fifo_full    (i_aw_fifo_full),
    .o_W_CHANNEL_fifo  (o_W_CHANNEL_fifo),
    .o_w_fifo_wr_en    (o_w_fifo_wr_en),
    .i_w_fifo_full     (i_w_fifo_full),
    .o_AR_CHANNEL_fifo (o_AR_CHANNEL_fifo),
    .o_ar_fifo_wr_en   (o_ar_fifo_wr_en),
    .i_ar_fifo_full    (i_ar_fifo_full),
    .o_len_err         (o_len_err)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // FIFO full-flag driver: off, toggling every cycle, or random stalls.
  initial begin
    i_aw_fifo_full = 1'b0;
    i_ar_fifo_full = 1'b0;
    i_w_fifo_full  = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (toggle_w) i_w_fifo_full = ~i_w_fifo_full;
      else if (stall_rand) i_w_fifo_full = ($urandom_range(0, 3) == 0);
      else i_w_fifo_full = 1'b0;
      i_aw_fifo_full = stall_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
      i_ar_fifo_full = stall_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  // Push monitor: a wr_en seen at negedge is a push at the following edge.
  always @(negedge i_clk) begin
    if (o_aw_fifo_wr_en) aw_q.push_back(o_AW_CHANNEL_fifo);
    if (o_ar_fifo_wr_en) ar_q.push_back(o_AR_CHANNEL_fifo);
    if (o_w_fifo_wr_en) begin
      wd_q.push_back(o_W_CHANNEL_fifo[W_CHANNEL_WIDTH-1:STROBE_BUS_WIDTH]);
      ws_q.push_back(o_W_CHANNEL_fifo[STROBE_BUS_WIDTH-1:0]);
    end
    if (o_len_err) err_pulses = err_pulses + 1;
  end

  function automatic req_t make_req(input logic we, input logic [63:0] addr,
                                    input logic [9:0] len_dw, input logic [3:0] fbe,
                                    input logic [3:0] lbe, input logic [9:0] tag,
                                    input logic [2:0] tc, input logic [11:0] user);
    req_t r;
    r.we = we; r.addr = addr; r.len_dw = len_dw; r.fbe = fbe; r.lbe = lbe;
    r.tag = tag; r.tc = tc; r.user = user;
    return r;
  endfunction

  function automatic int req_len(input req_t r);
    return (r.len_dw == 10'd0) ? 1024 : int'(r.len_dw);
  endfunction

  function automatic int req_beats(input req_t r);
    return (int'(r.addr[6:2]) + req_len(r) - 1) / 32 + 1;
  endfunction

  function automatic logic [99:0] exp_ax(input req_t r);
    int axlen;
    axlen = (int'(r.addr[6:2]) + req_len(r) - 1) / 32;
    return {r.tag, r.addr, 8'(axlen), 2'b01, 1'b0, r.tc, r.user};
  endfunction

  // Walk every DW of the request and place its byte enables into the beat
  // and lane where that DW lands.
  function automatic logic [127:0] exp_strb(input req_t r, input int beat);
    logic [127:0] st;
    logic [3:0]   be;
    int           len;
    int           pos;
    st  = '0;
    len = req_len(r);
    for (int k = 0; k < len; k++) begin
      pos = int'(r.addr[6:2]) + k;
      if (pos / 32 == beat) begin
        if (k == 0) be = r.fbe;
        else if (k == len - 1) be = r.lbe;
        else be = 4'hF;
        st[(pos % 32) * 4 +: 4] = be;
      end
    end
    return st;
  endfunction

  task automatic checkOutput(input string name, input logic [511:0] observed,
                             input logic [511:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $error("[TB] FAIL %s timeout observed=no-event expected=event", name);
  endtask

  task automatic clearQueues();
    aw_q.delete(); ar_q.delete(); wd_q.delete(); ws_q.delete(); sent_q.delete();
    err_pulses = 0;
  endtask

  // Header handshake, then wait until the matching AW/AR push edge has
  // passed. Returns at posedge+1 with the request in W_STREAM or IDLE.
  task automatic sendHeader(input req_t r);
    int guard;
    @(posedge i_clk);
    #1;
    i_tlp_is_write = r.we;  i_tlp_addr = r.addr;  i_tlp_len_dw = r.len_dw;
    i_tlp_first_be = r.fbe; i_tlp_last_be = r.lbe; i_tlp_tag = r.tag;
    i_tlp_tc = r.tc;        i_tlp_user = r.user;   i_tlp_valid = 1'b1;
    guard = 0;
    @(negedge i_clk);
    while (!o_tlp_ready && guard < 100) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_tlp_ready) timeoutFail("tlp_ready");
    @(posedge i_clk);
    #1;
    i_tlp_valid = 1'b0;
    @(negedge i_clk);
    if (r.we) checkOutput("aw_wr_en_after_hdr", 512'(o_aw_fifo_wr_en), 512'(!i_aw_fifo_full));
    else checkOutput("ar_wr_en_after_hdr", 512'(o_ar_fifo_wr_en), 512'(!i_ar_fifo_full));
    guard = 0;
    while (!(r.we ? o_aw_fifo_wr_en : o_ar_fifo_wr_en) && guard < 100) begin
      @(negedge i_clk);
      guard++;
    end
    if (!(r.we ? o_aw_fifo_wr_en : o_ar_fifo_wr_en)) timeoutFail("ax_push");
    @(posedge i_clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; ready must mirror !full.
  task automatic sendBeat(input logic [1023:0] d, input logic last);
    int guard;
    i_data_valid = 1'b1;
    i_data       = d;
    i_data_last  = last;
    sent_q.push_back(d);
    guard = 0;
    @(negedge i_clk);
    checkOutput("data_ready_tracks_full", 512'(o_data_ready), 512'(!i_w_fifo_full));
    while (!o_data_ready && guard < 200) begin
      @(negedge i_clk);
      checkOutput("data_ready_tracks_full", 512'(o_data_ready), 512'(!i_w_fifo_full));
      guard++;
    end
    if (!o_data_ready) timeoutFail("w_beat_accept");
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [1023:0] randBeat();
    logic [1023:0] d;
    for (int w = 0; w < 32; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  // A whole request; bad_beat >= 0 inverts i_data_last on that beat.
  task automatic applyStimulus(input req_t r, input int bad_beat);
    int nbeats;
    clearQueues();
    sendHeader(r);
    if (r.we) begin
      nbeats = req_beats(r);
      for (int b = 0; b < nbeats; b++) begin
        sendBeat(randBeat(), (b == nbeats - 1) != (b == bad_beat));
      end
      i_data_valid = 1'b0;
      i_data_last  = 1'b0;
    end
    repeat (3) @(negedge i_clk);
  endtask

  task automatic verifyRequest(input req_t r, input int bad_beat);
    int nbeats;
    nbeats = req_beats(r);
    if (r.we) begin
      checkOutput("aw_count", 512'(aw_q.size()), 512'(1));
      checkOutput("ar_count", 512'(ar_q.size()), 512'(0));
      checkOutput("aw_entry", 512'((aw_q.size() > 0) ? aw_q[0] : '0), 512'(exp_ax(r)));
      checkOutput("w_count", 512'(wd_q.size()), 512'(nbeats));
      for (int b = 0; b < nbeats && b < wd_q.size(); b++) begin
        checkOutput("w_data_lo", wd_q[b][511:0], sent_q[b][511:0]);
        checkOutput("w_data_hi", wd_q[b][1023:512], sent_q[b][1023:512]);
        checkOutput("w_strb", 512'(ws_q[b]), 512'(exp_strb(r, b)));
      end
      checkOutput("len_err_pulses", 512'(err_pulses), 512'((bad_beat >= 0) ? 1 : 0));
    end else begin
      checkOutput("ar_count", 512'(ar_q.size()), 512'(1));
      checkOutput("aw_count", 512'(aw_q.size()), 512'(0));
      checkOutput("w_count", 512'(wd_q.size()), 512'(0));
      checkOutput("ar_entry", 512'((ar_q.size() > 0) ? ar_q[0] : '0), 512'(exp_ax(r)));
      checkOutput("len_err_pulses", 512'(err_pulses), 512'(0));
    end
  endtask

  initial begin
    req_t        r;
    logic [99:0] ax;
    logic        rand_we;

    i_rst = 1'b1;        i_tlp_valid = 1'b0;   i_tlp_is_write = 1'b0;
    i_tlp_addr = '0;     i_tlp_len_dw = '0;    i_tlp_first_be = '0;
    i_tlp_last_be = '0;  i_tlp_tag = '0;       i_tlp_tc = '0;
    i_tlp_user = '0;     i_data_valid = 1'b0;  i_data = '0;
    i_data_last = 1'b0;  err_pulses = 0;
    $display("[TB] start");

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    @(negedge i_clk);
    checkOutput("rst_tlp_ready", 512'(o_tlp_ready), 512'(1));
    checkOutput("rst_aw_wr_en", 512'(o_aw_fifo_wr_en), 512'(0));
    checkOutput("rst_ar_wr_en", 512'(o_ar_fifo_wr_en), 512'(0));
    checkOutput("rst_w_wr_en", 512'(o_w_fifo_wr_en), 512'(0));
    checkOutput("rst_data_ready", 512'(o_data_ready), 512'(0));
    checkOutput("rst_len_err", 512'(o_len_err), 512'(0));

    // MRd 0x1000, 64 DW
    r = make_req(1'b0, 64'h1000, 10'd64, 4'hF, 4'hF, 10'h2A5, 3'd3, 12'h123);
    applyStimulus(r, -1);
    verifyRequest(r, -1);
    ax = (ar_q.size() > 0) ? ar_q[0] : '0;
    checkOutput("mrd_id", 512'(ax[99:90]), 512'(10'h2A5));
    checkOutput("mrd_len", 512'(ax[25:18]), 512'(8'd1));
    checkOutput("mrd_burst", 512'(ax[17:16]), 512'(2'b01));
    checkOutput("mrd_qos", 512'(ax[15:12]), 512'(4'h3));

    // MWr single DW at 0x1004
    r = make_req(1'b1, 64'h1004, 10'd1, 4'h6, 4'hF, 10'h011, 3'd0, 12'h000);
    applyStimulus(r, -1);
    verifyRequest(r, -1);
    ax = (aw_q.size() > 0) ? aw_q[0] : '0;
    checkOutput("sdw_aw_len", 512'(ax[25:18]), 512'(8'd0));
    checkOutput("sdw_strb", 512'((ws_q.size() > 0) ? ws_q[0] : '0), 512'(128'h60));

    // MWr crossing a beat boundary at 0x2078
    r = make_req(1'b1, 64'h2078, 10'd4, 4'hF, 4'h3, 10'h0F0, 3'd5, 12'hABC);
    applyStimulus(r, -1);
    verifyRequest(r, -1);
    ax = (aw_q.size() > 0) ? aw_q[0] : '0;
    checkOutput("cross_aw_len", 512'(ax[25:18]), 512'(8'd1));
    checkOutput("cross_strb0", 512'((ws_q.size() > 0) ? ws_q[0] : '0), 512'({8'hFF, 120'h0}));
    checkOutput("cross_strb1_lo", 512'((ws_q.size() > 1) ? ws_q[1][7:0] : 8'h0), 512'(8'h3F));

    // MWr of 1024 DW at 0
    r = make_req(1'b1, 64'h0, 10'd0, 4'hF, 4'hF, 10'h3FF, 3'd7, 12'hFFF);
    applyStimulus(r, -1);
    verifyRequest(r, -1);
    ax = (aw_q.size() > 0) ? aw_q[0] : '0;
    checkOutput("max_aw_len", 512'(ax[25:18]), 512'(8'd31));

    // 40 DW with the W FIFO full every other cycle
    toggle_w = 1'b1;
    r = make_req(1'b1, 64'h4000, 10'd40, 4'hC, 4'h1, 10'h155, 3'd2, 12'h5A5);
    applyStimulus(r, -1);
    verifyRequest(r, -1);
    toggle_w = 1'b0;

    // i_data_last early on a non-final beat, then missing on the final beat
    r = make_req(1'b1, 64'h8040, 10'd70, 4'hF, 4'h7, 10'h022, 3'd1, 12'h321);
    applyStimulus(r, 0);
    verifyRequest(r, 0);
    r = make_req(1'b1, 64'h9000, 10'd33, 4'hE, 4'hF, 10'h023, 3'd4, 12'h654);
    applyStimulus(r, req_beats(r) - 1);
    verifyRequest(r, req_beats(r) - 1);

    // Reset during beat 1 of a 3-beat write
    r = make_req(1'b1, 64'h0, 10'd70, 4'hF, 4'hF, 10'h077, 3'd0, 12'h777);
    clearQueues();
    sendHeader(r);
    sendBeat(randBeat(), 1'b0);
    i_data = randBeat();
    i_data_last = 1'b0;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    i_data_valid = 1'b0;
    @(negedge i_clk);
    checkOutput("midrst_aw_wr_en", 512'(o_aw_fifo_wr_en), 512'(0));
    checkOutput("midrst_ar_wr_en", 512'(o_ar_fifo_wr_en), 512'(0));
    checkOutput("midrst_w_wr_en", 512'(o_w_fifo_wr_en), 512'(0));
    checkOutput("midrst_tlp_ready", 512'(o_tlp_ready), 512'(1));
    checkOutput("midrst_data_ready", 512'(o_data_ready), 512'(0));
    checkOutput("midrst_len_err", 512'(o_len_err), 512'(0));
    r = make_req(1'b0, 64'h00C0_0000_1234_5678, 10'd200, 4'hF, 4'hF, 10'h078, 3'd6, 12'h888);
    applyStimulus(r, -1);
    verifyRequest(r, -1);
    r = make_req(1'b1, 64'h3004, 10'd5, 4'h8, 4'h1, 10'h079, 3'd2, 12'h999);
    applyStimulus(r, -1);
    verifyRequest(r, -1);

    // Random requests with random FIFO stalls
    stall_rand = 1'b1;
    for (int n = 0; n < 10; n++) begin
      rand_we = 1'($urandom_range(0, 1));
      r = make_req(rand_we, {$urandom, $urandom} & ~64'h3, 10'($urandom_range(0, 150)),
                   4'($urandom), 4'($urandom), 10'($urandom), 3'($urandom), 12'($urandom));
      applyStimulus(r, -1);
      verifyRequest(r, -1);
    end
    stall_rand = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_master_request_packer.md
Name: axi_master_request_packer

Overview:
- Upstream feeder of the AXI master request controller in TL_RX.
- Takes decoded memory-request TLP headers and address-aligned payload beats from the RX buffer.
- Packs them into AW, W and AR FIFO entries, computing AxLEN, burst type, QoS and per-beat WSTRB.
- One request is in flight at a time; all FIFO pushes respect the full flags.

Parameters:
- DW, 32, bits per double-word.
- BEAT_SIZE, 32*DW, W data bus width (128 bytes).
- ADDR_WIDTH, 64, request address width.
- ID_WIDTH, 10, AxID width; carries the extended PCIe tag.
- AxLEN_FIELD_WIDTH, 8, AxLEN width.
- QOS_WIDTH, 4, AxQOS width.
- USER_SIG_WIDTH, 12, AxUSER width; passed through unchanged.
- Ax_CHANNEL_WIDTH, 100, ID+ADDR+LEN+BURST(2)+QOS+USER.
- STROBE_BUS_WIDTH, 128, equals BEAT_SIZE/8.
- W_CHANNEL_WIDTH, BEAT_SIZE+STROBE_BUS_WIDTH, W FIFO entry width.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_tlp_valid  in  1  header valid.
- o_tlp_ready  out  1  header accepted when valid&&ready.
- i_tlp_is_write  in  1  1=MWr, 0=MRd.
- i_tlp_addr  in  ADDR_WIDTH  byte address; bits [1:0] are 0.
- i_tlp_len_dw  in  10  length in DW; 0 encodes 1024.
- i_tlp_first_be  in  4  byte enables of the first DW.
- i_tlp_last_be  in  4  byte enables of the last DW.
- i_tlp_tag  in  ID_WIDTH  tag; becomes AxID.
- i_tlp_tc  in  3  traffic class.
- i_tlp_user  in  USER_SIG_WIDTH  AxUSER.
- i_data_valid  in  1  payload beat valid.
- i_data  in  BEAT_SIZE  payload beat, placed at address byte lanes.
- i_data_last  in  1  upstream last-beat marker.
- o_data_ready  out  1  payload beat accepted.
- o_AW_CHANNEL_fifo  out  Ax_CHANNEL_WIDTH  {ID,ADDR,LEN,BURST,QOS,USER}.
- o_aw_fifo_wr_en  out  1  AW push.
- i_aw_fifo_full  in  1  AW FIFO full.
- o_W_CHANNEL_fifo  out  W_CHANNEL_WIDTH  {DATA,STRB}.
- o_w_fifo_wr_en  out  1  W push.
- i_w_fifo_full  in  1  W FIFO full.
- o_AR_CHANNEL_fifo  out  Ax_CHANNEL_WIDTH  {ID,ADDR,LEN,BURST,QOS,USER}.
- o_ar_fifo_wr_en  out  1  AR push.
- i_ar_fifo_full  in  1  AR FIFO full.
- o_len_err  out  1  one-cycle pulse on i_data_last mismatch.

Behaviour:
- Reset (i_rst=1 at posedge):
  - state=IDLE, beat counter=0.
  - All wr_en, o_data_ready, o_len_err = 0; o_tlp_ready = 1 the following cycle.
  - Reset mid-burst discards the partial W burst; the FIFOs share this reset.
- FSM states: IDLE, HDR_PUSH, W_STREAM.
  - IDLE: o_tlp_ready=1. On header handshake, register all fields plus derived values, then go to HDR_PUSH.
  - HDR_PUSH: o_tlp_ready=0.
    - Write: o_aw_fifo_wr_en=!i_aw_fifo_full. On push, go to W_STREAM with counter=0.
    - Read: o_ar_fifo_wr_en=!i_ar_fifo_full. On push, go to IDLE.
    - While the target FIFO is full, hold with wr_en low.
  - W_STREAM: o_data_ready=!i_w_fifo_full, and o_w_fifo_wr_en=i_data_valid&&o_data_ready (same cycle, combinational).
    - Each push increments the counter.
    - On the push where counter==AxLEN, go to IDLE.
- Minimum latency:
  - Read: header→AR push is 1 cycle.
  - Write: header→AW push is 1 cycle; the first W push is possible the cycle after the AW push.
- Arithmetic:
  - len = (i_tlp_len_dw==0) ? 1024 : i_tlp_len_dw, 11 bits.
  - s = addr[6:2].
  - e = s+len-1, 11 bits.
  - AxLEN = e[10:5], zero-extended to 8 bits; maximum is 32.
  - AxBURST = INCR (2'b01).
  - AxQOS = {1'b0, tc}.
  - AxADDR = the registered address, unmodified.
- Strobe for beat b, DW lane j, with global index g=b*32+j:
  - 4'hF if s<g<e.
  - first_be at g==s.
  - last_be at g==e (when len>1).
  - 0 outside [s,e].
  - When len==1, only first_be is used; last_be is ignored.
- i_data_last:
  - If asserted on a non-final beat, or absent on the final beat, pulse o_len_err in the cycle after that beat.
  - The FSM always follows its own count.
- The AR and AW/W paths are never active simultaneously; header order is preserved.

Decomposition:
- Shared package axi_master_pkg:
  - burst encodings FIXED/INCREMENT/WRAP;
  - FSM state encodings;
  - Ax field widths;
  - the Ax_CHANNEL_WIDTH computation, shared with the request controller.
- Sub-module axi_master_strobe_gen: combinational. Inputs s, e, beat index, first_be, last_be; output STROBE_BUS_WIDTH strobe.

Test Plan:
- MRd at addr=0x1000, len_dw=64, tag=0x2A5, tc=3, AR not full → AR push 1 cycle after the header with ID=0x2A5, LEN=1, BURST=01, QOS=4'h3.
- MWr at addr=0x1004, len_dw=1, first_be=4'h6 → AW LEN=0; one W beat with WSTRB bits[7:4]=4'b0110, all others 0; no o_len_err.
- MWr at addr=0x2078, len_dw=4, first_be=F, last_be=3 →
  - AW LEN=1;
  - beat0 WSTRB=0xFF<<120;
  - beat1 WSTRB[7:0]=0x3F.
- MWr with len_dw=0 at addr=0 → AW LEN=31; 32 W pushes, all full strobes.
- MWr with len_dw=40, i_w_fifo_full toggled every other cycle → o_data_ready tracks !full; exactly 2 pushes; no beat lost or duplicated.
- i_rst asserted mid W_STREAM (beat 1 of 3) → next cycle all wr_en=0 and o_tlp_ready=1; a new header is accepted normally.
